// File: rtl/register_file_scoreboard_pkg.sv
// Shared definitions for the GPR file: size codes, register names and the
// alias/lane helpers used by both the write path and every read port.
package register_file_scoreboard_pkg;

  typedef enum logic [2:0] {
    SZ_8  = 3'd0,
    SZ_16 = 3'd1,
    SZ_32 = 3'd2
  } size_e;

  typedef enum logic [2:0] {
    EAX = 3'd0,
    ECX = 3'd1,
    EDX = 3'd2,
    EBX = 3'd3,
    ESP = 3'd4,
    EBP = 3'd5,
    ESI = 3'd6,
    EDI = 3'd7
  } gpr_e;

  // 8-bit numbers 4-7 name AH/CH/DH/BH, which live in registers 0-3.
  function automatic logic [2:0] phys_num(input logic [2:0] size, input logic [2:0] num);
    return (size == SZ_8) ? {1'b0, num[1:0]} : num;
  endfunction

  function automatic logic is_high_byte(input logic [2:0] size, input logic [2:0] num);
    return (size == SZ_8) && num[2];
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] data,
                                              input logic [2:0]  size,
                                              input logic [2:0]  num);
    logic [31:0] res;
    case (size)
      SZ_8:    res = is_high_byte(size, num) ? {old_val[31:16], data[7:0], old_val[7:0]}
                                             : {old_val[31:8], data[7:0]};
      SZ_16:   res = {old_val[31:16], data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/register_file_scoreboard_read_port.sv
// One operand read port: alias mapping, write-first forwarding of the
// same-cycle writeback, and the RAW hazard check against pending writes.
module gpr_read_port
  import register_file_scoreboard_pkg::*;
(
  input  logic        rd_en,
  input  logic [2:0]  rd_num,
  input  logic [2:0]  size,
  input  logic [31:0] regs [8],
  input  logic [7:0]  pend,
  input  logic        wb_en,
  input  logic [2:0]  wb_num,
  input  logic [2:0]  wb_size,
  input  logic [31:0] wb_data,
  output logic [31:0] rd_data,
  output logic        hazard
);

  logic [2:0]  p;
  logic [31:0] cur;

  always_comb begin
    p   = phys_num(size, rd_num);
    cur = regs[p];
    if (wb_en && (phys_num(wb_size, wb_num) == p)) begin
      cur = merge_lanes(cur, wb_data, wb_size, wb_num);
    end
    rd_data = '0;
    if (rd_en) begin
      case (size)
        SZ_8:    rd_data = is_high_byte(size, rd_num) ? {24'h0, cur[15:8]} : {24'h0, cur[7:0]};
        SZ_16:   rd_data = {16'h0, cur[15:0]};
        default: rd_data = cur;
      endcase
    end
    hazard = rd_en && pend[p];
  end

endmodule

// File: rtl/register_file_scoreboard.sv
// GPR file with per-register pending-write scoreboard, NUM_RD size-aware
// read ports and a one-entry valid/ready output register.
module register_file_scoreboard
  import register_file_scoreboard_pkg::*;
#(
  parameter int          NUM_RD    = 2,
  parameter int          SB_W      = 2,
  parameter logic [31:0] RESET_ESP = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   d_valid,
  output logic                   d_ready,
  input  logic [2:0]             d_size,
  input  logic [NUM_RD-1:0]      d_rd_en,
  input  logic [3*NUM_RD-1:0]    d_rd_num,
  input  logic                   d_wr_en,
  input  logic [2:0]             d_wr_num,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [2:0]             r_size,
  output logic [32*NUM_RD-1:0]   r_rd_data,
  output logic                   r_wr_en,
  output logic [2:0]             r_wr_num,
  input  logic                   wb_reg_en,
  input  logic [2:0]             wb_reg_number,
  input  logic [2:0]             wb_reg_size,
  input  logic [31:0]            wb_reg_data,
  input  logic                   wb_release
);

  localparam logic [SB_W-1:0] CNT_MAX = '1;

  logic [31:0]        regs [8];
  logic [SB_W-1:0]    cnt  [8];
  logic [7:0]         rel;
  logic [7:0]         inc;
  logic [7:0]         pend;
  logic [2:0]         wb_phys;
  logic [2:0]         claim_phys;
  logic               claim_stall;
  logic               accept;
  logic [NUM_RD-1:0]  hazard;
  logic [32*NUM_RD-1:0] rd_data;

  assign wb_phys     = phys_num(wb_reg_size, wb_reg_number);
  assign claim_phys  = phys_num(d_size, d_wr_num);
  // Saturation is judged on the count before any same-cycle release.
  assign claim_stall = d_wr_en && (cnt[claim_phys] == CNT_MAX);
  assign d_ready     = (!r_valid || r_ready) && !(|hazard) && !claim_stall && !flush;
  assign accept      = d_valid && d_ready;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rel[i]  = wb_release && (wb_phys == 3'(i)) && (cnt[i] != '0);
      inc[i]  = accept && d_wr_en && (claim_phys == 3'(i));
      pend[i] = (cnt[i] - SB_W'(rel[i])) != '0;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    gpr_read_port u_port (
      .rd_en   (d_rd_en[g]),
      .rd_num  (d_rd_num[3*g +: 3]),
      .size    (d_size),
      .regs    (regs),
      .pend    (pend),
      .wb_en   (wb_reg_en),
      .wb_num  (wb_reg_number),
      .wb_size (wb_reg_size),
      .wb_data (wb_reg_data),
      .rd_data (rd_data[32*g +: 32]),
      .hazard  (hazard[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= (i == 4) ? RESET_ESP : 32'h0;
        cnt[i]  <= '0;
      end
      r_valid   <= 1'b0;
      r_size    <= '0;
      r_rd_data <= '0;
      r_wr_en   <= 1'b0;
      r_wr_num  <= '0;
    end else begin
      if (wb_reg_en) begin
        regs[wb_phys] <= merge_lanes(regs[wb_phys], wb_reg_data, wb_reg_size, wb_reg_number);
      end
      for (int i = 0; i < 8; i++) begin
        if (flush) cnt[i] <= '0;
        else       cnt[i] <= cnt[i] + SB_W'(inc[i]) - SB_W'(rel[i]);
      end
      if (flush) begin
        r_valid <= 1'b0;
      end else if (accept) begin
        r_valid   <= 1'b1;
        r_size    <= d_size;
        r_rd_data <= rd_data;
        r_wr_en   <= d_wr_en;
        r_wr_num  <= d_wr_num;
      end else if (r_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Randomised and directed checks of register_file_scoreboard against an
// array/counter reference model of the GPR file and scoreboard.
module tb_register_file_scoreboard;

  localparam int          NUM_RD    = 2;
  localparam int          SB_W      = 2;
  localparam int          MAXC      = (1 << SB_W) - 1;
  localparam logic [31:0] RESET_ESP = 32'h7FFF0;

  logic        clk = 1'b0;
  logic        reset, flush, d_valid, d_ready, d_wr_en, r_valid, r_ready;
  logic [2:0]  d_size, d_wr_num, r_size, r_wr_num;
  logic [1:0]  d_rd_en;
  logic [5:0]  d_rd_num;
  logic [63:0] r_rd_data;
  logic        r_wr_en, wb_reg_en, wb_release;
  logic [2:0]  wb_reg_number, wb_reg_size;
  logic [31:0] wb_reg_data;

  register_file_scoreboard #(.NUM_RD(NUM_RD), .SB_W(SB_W), .RESET_ESP(RESET_ESP)) dut (
    .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid), .d_ready(d_ready),
    .d_size(d_size), .d_rd_en(d_rd_en), .d_rd_num(d_rd_num), .d_wr_en(d_wr_en),
    .d_wr_num(d_wr_num), .r_valid(r_valid), .r_ready(r_ready), .r_size(r_size),
    .r_rd_data(r_rd_data), .r_wr_en(r_wr_en), .r_wr_num(r_wr_num),
    .wb_reg_en(wb_reg_en), .wb_reg_number(wb_reg_number), .wb_reg_size(wb_reg_size),
    .wb_reg_data(wb_reg_data), .wb_release(wb_release)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] m_reg [8];
  int          m_cnt [8];
  bit          m_rv;
  logic [2:0]  m_rsize, m_rwnum;
  bit          m_rwen;
  logic [63:0] m_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int phys_of(input int sz, input int n);
    return (sz == 0 && n >= 4) ? n - 4 : n;
  endfunction

  function automatic logic [31:0] rd_field(input logic [31:0] v, input int sz, input int n);
    if (sz == 0) return (n >= 4) ? (v >> 8) & 32'hFF : v & 32'hFF;
    if (sz == 1) return v & 32'hFFFF;
    return v;
  endfunction

  function automatic logic [31:0] wr_field(input logic [31:0] old, input logic [31:0] d,
                                           input int sz, input int n);
    if (sz == 0 && n >= 4) return (old & ~32'hFF00) | ((d & 32'hFF) << 8);
    if (sz == 0)           return (old & ~32'hFF) | (d & 32'hFF);
    if (sz == 1)           return (old & 32'hFFFF0000) | (d & 32'hFFFF);
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i] = (i == 4) ? RESET_ESP : 32'h0;
      m_cnt[i] = 0;
    end
    m_rv = 0; m_rsize = 0; m_rwnum = 0; m_rwen = 0; m_rdata = 0;
  endtask

  function automatic bit model_ready();
    bit haz = 0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (d_rd_en[i]) begin
        int p = phys_of(d_size, d_rd_num[3*i +: 3]);
        int c = m_cnt[p];
        if (wb_release && phys_of(wb_reg_size, wb_reg_number) == p && c > 0) c--;
        if (c != 0) haz = 1;
      end
    end
    if (d_wr_en && m_cnt[phys_of(d_size, d_wr_num)] == MAXC) return 0;
    return (!m_rv || r_ready) && !haz && !flush;
  endfunction

  task automatic model_clock();
    bit acc;
    int pw;
    if (reset) begin
      model_reset();
      return;
    end
    acc = d_valid && model_ready();
    pw  = phys_of(wb_reg_size, wb_reg_number);
    if (wb_reg_en) m_reg[pw] = wr_field(m_reg[pw], wb_reg_data, wb_reg_size, wb_reg_number);
    if (acc) begin
      for (int i = 0; i < NUM_RD; i++) begin
        int n = d_rd_num[3*i +: 3];
        m_rdata[32*i +: 32] = d_rd_en[i] ? rd_field(m_reg[phys_of(d_size, n)], d_size, n) : 32'h0;
      end
      m_rsize = d_size; m_rwen = d_wr_en; m_rwnum = d_wr_num;
    end
    if (flush) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    end else begin
      if (wb_release && m_cnt[pw] > 0) m_cnt[pw]--;
      if (acc && d_wr_en) m_cnt[phys_of(d_size, d_wr_num)]++;
    end
    if (flush)        m_rv = 0;
    else if (acc)     m_rv = 1;
    else if (r_ready) m_rv = 0;
  endtask

  task automatic tick();
    #1;
    if (!reset) check("d_ready", d_ready, model_ready());
    @(posedge clk);
    model_clock();
    #1;
    check("r_valid", r_valid, m_rv);
    check("r_size", r_size, m_rsize);
    check("r_wr_en", r_wr_en, m_rwen);
    check("r_wr_num", r_wr_num, m_rwnum);
    check("r_rd_data", r_rd_data, m_rdata);
  endtask

  task automatic idle();
    reset = 0; flush = 0; d_valid = 0; d_size = 2; d_rd_en = 0; d_rd_num = 0;
    d_wr_en = 0; d_wr_num = 0; r_ready = 1; wb_reg_en = 0; wb_reg_number = 0;
    wb_reg_size = 2; wb_reg_data = 0; wb_release = 0;
  endtask

  task automatic req(input int sz, input logic [1:0] en, input int n0, input int n1,
                     input bit wen, input int wn);
    idle();
    d_valid = 1; d_size = 3'(sz); d_rd_en = en;
    d_rd_num = {3'(n1), 3'(n0)}; d_wr_en = wen; d_wr_num = 3'(wn);
  endtask

  task automatic wb(input int n, input int sz, input logic [31:0] d, input bit rel);
    wb_reg_en = 1; wb_reg_number = 3'(n); wb_reg_size = 3'(sz);
    wb_reg_data = d; wb_release = rel;
  endtask

  task automatic expect_ready(input string tag, input bit exp);
    #1;
    check(tag, d_ready, exp);
  endtask

  logic [63:0] held;

  initial begin
    idle();
    reset = 1;
    model_reset();
    @(posedge clk); #1;
    tick();
    check("rst_rdata", r_rd_data, 64'h0);
    idle();
    expect_ready("rst_ready", 1);
    req(2, 2'b01, 4, 0, 0, 0);
    tick();
    check("rst_esp", r_rd_data[31:0], 32'h7FFF0);

    // Partial writes
    idle(); wb(0, 2, 32'h11223344, 0); tick();
    idle(); wb(4, 0, 32'h000000AA, 0); tick();
    req(2, 2'b01, 0, 0, 0, 0); tick();
    check("eax32", r_rd_data[31:0], 32'h1122AA44);
    req(0, 2'b11, 4, 0, 0, 0); tick();
    check("ah8", r_rd_data[31:0], 32'h000000AA);
    check("al8", r_rd_data[63:32], 32'h00000044);

    // RAW stall resolved by release with forwarded data
    req(2, 2'b00, 0, 0, 1, 1); tick();
    req(2, 2'b01, 1, 0, 0, 0);
    expect_ready("raw_stall0", 0); tick();
    expect_ready("raw_stall1", 0); tick();
    wb(1, 2, 32'h5, 1);
    expect_ready("raw_release", 1); tick();
    check("raw_fwd", r_rd_data[31:0], 32'h5);

    // Scoreboard saturation on EDX
    for (int k = 0; k < 3; k++) begin
      req(2, 2'b00, 0, 0, 1, 2);
      expect_ready("sat_claim", 1); tick();
    end
    req(2, 2'b00, 0, 0, 1, 2);
    expect_ready("sat_stall", 0); tick();
    wb_release = 1; wb_reg_number = 2; wb_reg_size = 2;
    expect_ready("sat_rel_cycle", 0); tick();
    req(2, 2'b00, 0, 0, 1, 2);
    expect_ready("sat_after_rel", 1); tick();

    // Back-pressure
    req(2, 2'b01, 0, 0, 0, 0); tick();
    held = r_rd_data;
    for (int k = 0; k < 3; k++) begin
      req(2, 2'b01, 3, 0, 0, 0); r_ready = 0;
      expect_ready("bp_ready", 0); tick();
      check("bp_hold", r_rd_data, held);
    end
    req(2, 2'b01, 3, 0, 0, 0);
    expect_ready("bp_release", 1); tick();

    // Flush clears outstanding claims
    req(2, 2'b00, 0, 0, 1, 3); tick();
    req(2, 2'b00, 0, 0, 1, 3); tick();
    idle(); flush = 1; tick();
    check("flush_rvalid", r_valid, 1'b0);
    req(2, 2'b11, 3, 2, 0, 0);
    expect_ready("flush_read", 1); tick();

    // Randomised traffic
    for (int k = 0; k < 2000; k++) begin
      idle();
      reset      = ($urandom_range(0, 299) == 0);
      flush      = ($urandom_range(0, 49) == 0);
      d_valid    = ($urandom_range(0, 9) < 7);
      d_size     = 3'($urandom_range(0, 7));
      d_rd_en    = 2'($urandom);
      d_rd_num   = 6'($urandom);
      d_wr_en    = ($urandom_range(0, 9) < 4);
      d_wr_num   = 3'($urandom);
      r_ready    = ($urandom_range(0, 9) < 8);
      wb_reg_en  = ($urandom_range(0, 9) < 4);
      wb_reg_number = 3'($urandom);
      wb_reg_size   = 3'($urandom_range(0, 3));
      wb_reg_data   = $urandom;
      wb_release = ($urandom_range(0, 9) < 4);
      tick();
    end

    // Reset mid-stream
    idle(); wb(0, 2, 32'hDEADBEEF, 0); tick();
    req(2, 2'b01, 0, 0, 1, 5); tick();
    idle(); reset = 1; flush = 1; tick();
    check("mid_rst_rvalid", r_valid, 1'b0);
    idle();
    expect_ready("mid_rst_ready", 1);
    req(2, 2'b11, 0, 4, 0, 0); tick();
    check("mid_rst_eax", r_rd_data[31:0], 32'h0);
    check("mid_rst_esp", r_rd_data[63:32], 32'h7FFF0);
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
